alu_input_loader: RTL
=====================

# alu_input_loader

Sequential front end that sits directly upstream of the combinational ALU on the board. It captures operand A, operand B and the 6-bit operation code from the slide switches, one value per pushbutton press, in a fixed A → B → OP order. It holds the three values on registered outputs that drive the ALU's `operando_A`, `operando_B` and `cod_operacion` inputs. Raw buttons are synchronised, optionally debounced, and edge-detected internally, so each physical press loads exactly once.

## Interface
- `NBITS`, 8, operand width; equals the ALU `NBITS`.
- `COD_OP`, 6, operation-code width; equals the ALU `COD_OP`.
- `DEBOUNCE_CYCLES`, 1000000, consecutive stable cycles required before a debounced level changes; must be ≥ 2.
- `i_clk`  in  1  single system clock; all logic on its rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_switches`  in  NBITS  raw slide switches; `[COD_OP-1:0]` is used for the op code.
- `i_btn_a`  in  1  raw pushbutton; loads A.
- `i_btn_b`  in  1  raw pushbutton; loads B.
- `i_btn_op`  in  1  raw pushbutton; loads op code.
- `o_operando_A`  out  NBITS  registered operand A to the ALU.
- `o_operando_B`  out  NBITS  registered operand B to the ALU.
- `o_cod_operacion`  out  COD_OP  registered op code to the ALU.
- `o_state`  out  2  FSM state for LEDs: WAIT_A=00, WAIT_B=01, WAIT_OP=10, READY=11.
- `o_ready`  out  1  high while in READY.
- `o_done`  out  1  one-cycle pulse on entry to READY.

## Operation
- Per button: 2-FF synchroniser, optional debouncer, then a rising-edge detector (previous-level FF). The result is a one-cycle press pulse.
- FSM:
  - WAIT_A: on an A pulse, load `o_operando_A` ← `i_switches` and go to WAIT_B.
  - WAIT_B: on a B pulse, load `o_operando_B` and go to WAIT_OP.
  - WAIT_OP: on an OP pulse, load `o_cod_operacion` ← `i_switches[COD_OP-1:0]`, go to READY, and pulse `o_done`.
  - READY: on an A pulse, load A and go to WAIT_B; `o_ready` drops. B and OP pulses are ignored.
- Pulses for buttons not expected in the current state are ignored and do not change registers.
- Simultaneous pulses: only the pulse expected by the current state acts. At most one transition happens per cycle.
- Registers not being loaded hold their value in every state. Outputs stay stable for the ALU during reloads.
- Values are copied bit-exact with no sign handling; the ALU interprets them as signed.
- Reset values: all data outputs 0, `o_state`=00, `o_ready`=0, `o_done`=0. Synchroniser, edge and debounce FFs and counters are all 0.
- Reset mid-sequence or mid-debounce returns to WAIT_A and discards partial loads and counts.
- A button held through reset release is seen as a new press after release, because the edge FFs reset to 0.

## Timing
- Without debounce: a raw button rising before edge k loads the register at edge k+2. The new value is visible after k+2, and `o_state` updates on the same edge.
- With debounce: the debounced level changes `DEBOUNCE_CYCLES` edges after the synchronised level last changed and stayed stable. Total latency is `DEBOUNCE_CYCLES`+2 edges.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles restarts the counter and produces no pulse.
- `o_done` is high exactly the one cycle after the edge that enters READY.
- Switches are sampled in the same cycle the pulse is high; no synchroniser is applied to them, because they are quasi-static.
- Release of a button produces no action. A held button produces one pulse only.

## Configuration
- `ALU_INPUT_LOADER_DEBOUNCE_EN` defined: the debounce counter per button is compiled in, with latency as above.
- Not defined: no counters exist, `DEBOUNCE_CYCLES` is unused, and the synchronised level feeds the edge detector directly. This is used for fast simulation.

## Test plan
- Reset, then A press with sw=0x04, B press with 0x0C, OP press with 0x20: `o_operando_A`=0x04, `o_operando_B`=0x0C, `o_cod_operacion`=0x20, `o_state`=11, one `o_done` pulse. The ALU result is 0x10.
- In WAIT_A, press B and OP with sw=0xFF: all outputs stay 0 and `o_state` stays 00.
- In READY with sw=0x81, press B then A: B stays unchanged, A becomes 0x81, `o_state`=01, `o_ready`=0. B and op still drive the ALU.
- With debounce compiled in and `DEBOUNCE_CYCLES`=4: a 3-cycle glitch on `i_btn_a` causes no load. A clean press loads exactly once at edge 6, even when the button is held for 50 cycles.
- In WAIT_OP, raise `i_btn_a` and `i_btn_op` in the same cycle with sw=0x22: only the op code loads (0x22) and the state goes to READY.
- Assert `i_reset` for 1 cycle while in WAIT_OP with A=0x04: all outputs read 0 and `o_state`=00 on the next cycle.

Source files
------------

// File: rtl/alu_input_loader.sv
// alu_input_loader
//
// Sequential front end for the combinational ALU. It captures operand A,
// operand B and the operation code from the slide switches. Each value is
// loaded by its own pushbutton, and the loads always happen in the order
// A -> B -> OP. The three values are held on registered outputs that drive
// the ALU inputs.
//
// Raw buttons go through a 2-FF synchroniser, an optional debouncer and a
// rising-edge detector. Each physical press therefore produces exactly one
// one-cycle press pulse.
//
// Build option:
//   ALU_INPUT_LOADER_DEBOUNCE_EN  defined: one debounce counter per button.
//                                 undefined: the synchronised level feeds the
//                                 edge detector directly, and DEBOUNCE_CYCLES
//                                 is not used.
//
// Parameters:
//   NBITS            operand width (matches the ALU)
//   COD_OP           operation-code width (matches the ALU)
//   DEBOUNCE_CYCLES  number of consecutive stable cycles before the debounced
//                    level changes (>= 2)
//
// Ports:
//   i_clk            system clock; all logic runs on its rising edge
//   i_reset          synchronous, active-high reset
//   i_switches       raw slide switches; [COD_OP-1:0] supplies the op code
//   i_btn_a          raw pushbutton, loads operand A
//   i_btn_b          raw pushbutton, loads operand B
//   i_btn_op         raw pushbutton, loads the op code
//   o_operando_A     registered operand A
//   o_operando_B     registered operand B
//   o_cod_operacion  registered op code
//   o_state          FSM state for the LEDs
//   o_ready          high while all three values are loaded
//   o_done           one-cycle pulse on entry to READY
//
// FSM states:
//   state   | meaning
//   WAIT_A  | waiting for the operand A press
//   WAIT_B  | A loaded, waiting for the operand B press
//   WAIT_OP | A and B loaded, waiting for the op-code press
//   READY   | all loaded; only an A press (new sequence) is accepted

module alu_input_loader #(
  parameter int NBITS           = 8,
  parameter int COD_OP          = 6,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NBITS-1:0]  i_switches,
  input  logic              i_btn_a,
  input  logic              i_btn_b,
  input  logic              i_btn_op,
  output logic [NBITS-1:0]  o_operando_A,
  output logic [NBITS-1:0]  o_operando_B,
  output logic [COD_OP-1:0] o_cod_operacion,
  output logic [1:0]        o_state,
  output logic              o_ready,
  output logic              o_done
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce_cycles
    $error("alu_input_loader: DEBOUNCE_CYCLES must be >= 2");
  end

  if (COD_OP > NBITS) begin : g_bad_cod_op
    $error("alu_input_loader: COD_OP must not exceed NBITS");
  end

  localparam int NBTN   = 3;
  localparam int BTN_A  = 0;
  localparam int BTN_B  = 1;
  localparam int BTN_OP = 2;

  typedef enum logic [1:0] {
    WAIT_A  = 2'b00,
    WAIT_B  = 2'b01,
    WAIT_OP = 2'b10,
    READY   = 2'b11
  } state_t;

  logic [NBTN-1:0] btn_raw;
  logic [NBTN-1:0] sync1;
  logic [NBTN-1:0] sync2;
  logic [NBTN-1:0] level;
  logic [NBTN-1:0] level_prev;
  logic [NBTN-1:0] press;

  assign btn_raw = {i_btn_op, i_btn_b, i_btn_a};

  // Button conditioning: synchroniser
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

`ifdef ALU_INPUT_LOADER_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] db_cnt [NBTN];

  // Count consecutive cycles in which the synchronised input differs from
  // the debounced level. The level follows the input only after
  // DEBOUNCE_CYCLES such cycles. Any return to agreement clears the count,
  // so a short glitch restarts the count instead of accumulating.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      level <= '0;
      for (int i = 0; i < NBTN; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NBTN; i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_TC) begin
          level[i]  <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end
`else
  assign level = sync2;
`endif

  // Edge detector. It resets to 0, so a button held through reset release
  // is seen as a fresh press.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      level_prev <= '0;
    end else begin
      level_prev <= level;
    end
  end

  assign press = level & ~level_prev;

  // Loader FSM
  state_t state;
  state_t state_next;
  logic   load_a;
  logic   load_b;
  logic   load_op;

  logic [NBITS-1:0]  operand_a;
  logic [NBITS-1:0]  operand_b;
  logic [COD_OP-1:0] cod_op;
  logic              done;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= WAIT_A;
    end else begin
      state <= state_next;
    end
  end

  // Each state looks only at the one press it expects. Presses on other
  // buttons, including presses in the same cycle, are dropped, so at most
  // one transition happens per cycle.
  always_comb begin
    state_next = state;
    load_a     = 1'b0;
    load_b     = 1'b0;
    load_op    = 1'b0;
    unique case (state)
      WAIT_A: begin
        if (press[BTN_A]) begin
          load_a     = 1'b1;
          state_next = WAIT_B;
        end
      end
      WAIT_B: begin
        if (press[BTN_B]) begin
          load_b     = 1'b1;
          state_next = WAIT_OP;
        end
      end
      WAIT_OP: begin
        if (press[BTN_OP]) begin
          load_op    = 1'b1;
          state_next = READY;
        end
      end
      READY: begin
        if (press[BTN_A]) begin
          load_a     = 1'b1;
          state_next = WAIT_B;
        end
      end
      default: begin
        state_next = WAIT_A;
      end
    endcase
  end

  // Switches are quasi-static, so they are sampled directly in the cycle
  // the press pulse is high.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      operand_a <= '0;
      operand_b <= '0;
      cod_op    <= '0;
      done      <= 1'b0;
    end else begin
      if (load_a) begin
        operand_a <= i_switches;
      end
      if (load_b) begin
        operand_b <= i_switches;
      end
      if (load_op) begin
        cod_op <= i_switches[COD_OP-1:0];
      end
      done <= load_op;
    end
  end

  assign o_operando_A    = operand_a;
  assign o_operando_B    = operand_b;
  assign o_cod_operacion = cod_op;
  assign o_state         = state;
  assign o_ready         = (state == READY);
  assign o_done          = done;

endmodule
